execute_stage: RTL and testbench

//  EX stage of the 5-stage RV32I pipeline. Consumes the ID/EX register outputs (E-suffixed signals).

---
 rtl/execute_stage.sv | 203 ++++++++++++++++++++
 tb/tb_execute_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage RV32I pipeline.
// Selects forwarded operands, computes the ALU result, the branch/jump
// target and the PC-source select for the fetch stage, and registers the
// values the MEM stage needs in the EX/MEM pipeline register.
// PCSrcE, PCTargetE and ALUResultE are combinational; every *M output is
// registered.
module execute_stage #(
    parameter int WIDTH = 32              // datapath width; only 32 is supported
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active-low
    input  logic             StallM,       // hold the EX/MEM register
    input  logic             FlushM,       // synchronous bubble into EX/MEM
    input  logic [WIDTH-1:0] RD1E,
    input  logic [WIDTH-1:0] RD2E,
    input  logic [WIDTH-1:0] ExtImmE,
    input  logic [WIDTH-1:0] PCE,
    input  logic [WIDTH-1:0] PCPlus4E,
    input  logic [4:0]       RdE,
    input  logic [2:0]       ALUControlE,
    input  logic [1:0]       BranchE,
    input  logic             JumpE,
    input  logic             JalrE,
    input  logic             LuiE,
    input  logic             ALUSrcE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic [1:0]       ResultSrcE,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [WIDTH-1:0] ResultW,
    output logic [1:0]       PCSrcE,
    output logic [WIDTH-1:0] PCTargetE,
    output logic [WIDTH-1:0] ALUResultE,
    output logic [WIDTH-1:0] ALUResultM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [WIDTH-1:0] PCPlus4M,
    output logic [4:0]       RdM,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic [1:0]       ResultSrcM
);

    // Shift amount width: srl only looks at the low log2(WIDTH) bits of SrcB.
    localparam int SHAMT_W = $clog2(WIDTH);

    // ALU operation encoding carried on ALUControlE.
    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SLT  = 3'b101,
        ALU_SLTU = 3'b110,
        ALU_SRL  = 3'b111
    } alu_op_e;

    // Forwarding source select; code 11 is treated like 00 (register file).
    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,
        FWD_WB      = 2'b01,
        FWD_MEM     = 2'b10,
        FWD_REG_ALT = 2'b11
    } fwd_sel_e;

    // Conditional branch kind.
    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_BLT  = 2'b11
    } branch_e;

    // Next-PC source presented to the fetch-stage PC mux.
    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_TARGET = 2'b01,
        PC_JALR   = 2'b10
    } pc_src_e;

    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] write_data_e;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_out;
    logic             operands_eq;
    logic             operands_lt;
    logic             branch_taken;
    pc_src_e          pc_src;

    // Operand A: pick register value, writeback value or the EX/MEM result.
    always_comb begin
        unique case (fwd_sel_e'(ForwardAE))
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALUResultM;
            default: src_a = RD1E;
        endcase
    end

    // Operand B before the immediate mux; this is also the store data.
    always_comb begin
        unique case (fwd_sel_e'(ForwardBE))
            FWD_WB:  write_data_e = ResultW;
            FWD_MEM: write_data_e = ALUResultM;
            default: write_data_e = RD2E;
        endcase
    end

    assign src_b = ALUSrcE ? ExtImmE : write_data_e;

    // Shared adder/subtractor; the sum also feeds the jalr target.
    assign sum  = src_a + src_b;
    assign diff = src_a - src_b;

    // ALU operation select.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        alu_out = sum;
        unique case (alu_op_e'(ALUControlE))
            ALU_ADD:  alu_out = sum;
            ALU_SUB:  alu_out = diff;
            ALU_AND:  alu_out = src_a & src_b;
            ALU_OR:   alu_out = src_a | src_b;
            ALU_XOR:  alu_out = src_a ^ src_b;
            ALU_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            ALU_SRL:  alu_out = src_a >> src_b[SHAMT_W-1:0];
            default:  alu_out = sum;
        endcase
    end

    // Final EX result: lui passes the immediate, jalr forces an even target.
    always_comb begin
        if (LuiE) begin
            ALUResultE = ExtImmE;
        end else if (JalrE) begin
            ALUResultE = sum & ~{{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            ALUResultE = alu_out;
        end
    end

    // Branches compare the two register operands, never the immediate.
    assign operands_eq = (src_a == write_data_e);
    assign operands_lt = ($signed(src_a) < $signed(write_data_e));

    // Branch resolution from the branch kind and the operand comparison.
    always_comb begin
        unique case (branch_e'(BranchE))
            BR_BEQ:  branch_taken = operands_eq;
            BR_BNE:  branch_taken = !operands_eq;
            BR_BLT:  branch_taken = operands_lt;
            default: branch_taken = 1'b0;
        endcase
    end

    // PC-source select: jalr wins over jal and over a taken branch.
    always_comb begin
        if (JalrE) begin
            pc_src = PC_JALR;
        end else if (JumpE || branch_taken) begin
            pc_src = PC_TARGET;
        end else begin
            pc_src = PC_PLUS4;
        end
    end

    assign PCSrcE    = pc_src;
    assign PCTargetE = PCE + ExtImmE;

    // EX/MEM pipeline register: async clear, then flush, then stall, else load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            RdM        <= '0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
        end else if (FlushM) begin
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            RdM        <= '0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
        end else if (!StallM) begin
            ALUResultM <= ALUResultE;
            WriteDataM <= write_data_e;
            PCPlus4M   <= PCPlus4E;
            RdM        <= RdE;
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed self-checking bench for execute_stage.
// Inputs change one time unit after a rising edge; combinational outputs
// are checked shortly after, registered outputs one unit after the edge.
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        StallM, FlushM;
    logic [31:0] RD1E, RD2E, ExtImmE, PCE, PCPlus4E, ResultW;
    logic [4:0]  RdE;
    logic [2:0]  ALUControlE;
    logic [1:0]  BranchE;
    logic        JumpE, JalrE, LuiE, ALUSrcE, RegWriteE, MemWriteE;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic [1:0]  PCSrcE;
    logic [31:0] PCTargetE, ALUResultE, ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;

    int tests_run    = 0;
    int tests_failed = 0;

    execute_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .StallM(StallM), .FlushM(FlushM),
        .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RdE(RdE), .ALUControlE(ALUControlE), .BranchE(BranchE), .JumpE(JumpE),
        .JalrE(JalrE), .LuiE(LuiE), .ALUSrcE(ALUSrcE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE), .ResultW(ResultW), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .ALUResultE(ALUResultE), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h required %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        StallM = 0; FlushM = 0;
        RD1E = 0; RD2E = 0; ExtImmE = 0; PCE = 0; PCPlus4E = 0; ResultW = 0;
        RdE = 0; ALUControlE = 0; BranchE = 0; JumpE = 0; JalrE = 0; LuiE = 0;
        ALUSrcE = 0; RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0;
        ForwardAE = 0; ForwardBE = 0;
    endtask

    task automatic alu_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic [31:0] exp);
        clear_inputs();
        RD1E = a; RD2E = b; ALUControlE = op;
        #1;
        check(tag, ALUResultE, exp);
    endtask

    task automatic check_m_zero(input string pfx);
        check({pfx, " ALUResultM"}, ALUResultM, 32'h0);
        check({pfx, " WriteDataM"}, WriteDataM, 32'h0);
        check({pfx, " PCPlus4M"},   PCPlus4M,   32'h0);
        check({pfx, " RdM"},        {27'h0, RdM},        32'h0);
        check({pfx, " RegWriteM"},  {31'h0, RegWriteM},  32'h0);
        check({pfx, " MemWriteM"},  {31'h0, MemWriteM},  32'h0);
        check({pfx, " ResultSrcM"}, {30'h0, ResultSrcM}, 32'h0);
    endtask

    task automatic randomize_inputs();
        StallM = 1'($urandom); FlushM = 1'($urandom);
        RD1E = $urandom; RD2E = $urandom; ExtImmE = $urandom; PCE = $urandom;
        PCPlus4E = $urandom; ResultW = $urandom; RdE = 5'($urandom);
        ALUControlE = 3'($urandom); BranchE = 2'($urandom); JumpE = 1'($urandom);
        JalrE = 1'($urandom); LuiE = 1'($urandom); ALUSrcE = 1'($urandom);
        RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'($urandom);
        ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
    endtask

    initial begin
        // ---------------- reset with random inputs ----------------
        rst = 1'b1;
        randomize_inputs();
        #2 rst = 1'b0;
        #1 check_m_zero("rst async");
        for (int i = 0; i < 2; i++) begin
            step();
            randomize_inputs();
        end
        check_m_zero("rst held");

        // Release reset with a known instruction: first edge loads it.
        clear_inputs();
        RD1E = 32'hFFFF_FFFF; RD2E = 32'h1; ALUControlE = 3'b000;
        RdE = 5'd3; RegWriteE = 1; ResultSrcE = 2'b10; PCPlus4E = 32'h104;
        rst = 1'b1;
        #1 check("add wrap", ALUResultE, 32'h0);
        step();
        check("load RdM",        {27'h0, RdM},        32'd3);
        check("load RegWriteM",  {31'h0, RegWriteM},  32'd1);
        check("load PCPlus4M",   PCPlus4M,            32'h104);
        check("load WriteDataM", WriteDataM,          32'h1);
        check("load ResultSrcM", {30'h0, ResultSrcM}, 32'd2);
        check("load ALUResultM", ALUResultM,          32'h0);

        // ---------------- ALU ----------------
        alu_vec("sub 0-1",   32'h0,         32'h1,         3'b001, 32'hFFFF_FFFF);
        alu_vec("slt -1<1",  32'hFFFF_FFFF, 32'h1,         3'b101, 32'h1);
        alu_vec("sltu -1<1", 32'hFFFF_FFFF, 32'h1,         3'b110, 32'h0);
        alu_vec("slt 1<-1",  32'h1,         32'hFFFF_FFFF, 3'b101, 32'h0);
        alu_vec("srl 31",    32'h8000_0000, 32'd31,        3'b111, 32'h1);
        alu_vec("srl 4",     32'h8000_00F0, 32'hFFFF_FFE4, 3'b111, 32'h0800_000F);
        alu_vec("and",       32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b010, 32'h00F0_000F);
        alu_vec("or",        32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b011, 32'hFFF0_0FFF);
        alu_vec("xor",       32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b100, 32'hFF00_0FF0);

        // Immediate operand via ALUSrcE.
        clear_inputs();
        RD1E = 32'd100; RD2E = 32'd1; ExtImmE = 32'd23; ALUSrcE = 1;
        #1 check("add imm", ALUResultE, 32'd123);

        // lui ignores ALUControlE.
        clear_inputs();
        LuiE = 1; ExtImmE = 32'h1234_5000; RD1E = 32'h55; ALUControlE = 3'b001;
        #1 check("lui", ALUResultE, 32'h1234_5000);

        // ---------------- branches ----------------
        clear_inputs();
        RD1E = 5; RD2E = 5; PCE = 32'h100; ExtImmE = 32'hFFFF_FFF8;
        BranchE = 2'b01; ALUSrcE = 1;
        #1;
        check("beq taken PCSrcE", {30'h0, PCSrcE}, 32'd1);
        check("beq PCTargetE",    PCTargetE,       32'hF8);
        BranchE = 2'b10;
        #1 check("bne equal PCSrcE", {30'h0, PCSrcE}, 32'd0);
        RD2E = 6;
        #1 check("bne unequal PCSrcE", {30'h0, PCSrcE}, 32'd1);
        RD1E = 32'hFFFF_FFFF; RD2E = 1; BranchE = 2'b11;
        #1 check("blt -1<1 PCSrcE", {30'h0, PCSrcE}, 32'd1);
        RD1E = 1; RD2E = 32'hFFFF_FFFF;
        #1 check("blt 1<-1 PCSrcE", {30'h0, PCSrcE}, 32'd0);

        // ---------------- jumps ----------------
        clear_inputs();
        RD1E = 32'h203; ExtImmE = 0; ALUSrcE = 1; JalrE = 1; JumpE = 1;
        #1;
        check("jalr PCSrcE",     {30'h0, PCSrcE}, 32'd2);
        check("jalr ALUResultE", ALUResultE,      32'h202);
        JalrE = 0;
        #1 check("jal PCSrcE", {30'h0, PCSrcE}, 32'd1);
        clear_inputs();
        #1 check("idle PCSrcE", {30'h0, PCSrcE}, 32'd0);

        // ---------------- forwarding ----------------
        clear_inputs();
        RD1E = 3; RD2E = 4; RegWriteE = 1; RdE = 5'd1;
        step();
        check("fwd producer ALUResultM", ALUResultM, 32'd7);
        clear_inputs();
        RD1E = 32'hDEAD; ForwardAE = 2'b10; ALUSrcE = 1; ExtImmE = 3;
        RD2E = 32'h55; ForwardBE = 2'b01; ResultW = 9; MemWriteE = 1;
        #1 check("fwd MEM ALUResultE", ALUResultE, 32'd10);
        step();
        check("fwd WB WriteDataM",  WriteDataM,          32'd9);
        check("fwd MemWriteM",      {31'h0, MemWriteM},  32'd1);
        check("fwd ALUResultM",     ALUResultM,          32'd10);
        clear_inputs();
        RD1E = 32'd40; ResultW = 32'd2; ForwardAE = 2'b01; ALUSrcE = 1; ExtImmE = 1;
        #1 check("fwd A WB", ALUResultE, 32'd3);
        ForwardAE = 2'b11;
        #1 check("fwd A 11 reg", ALUResultE, 32'd41);

        // ---------------- stall ----------------
        clear_inputs();
        RD1E = 32'h11; RD2E = 32'h22; RdE = 5'd5; RegWriteE = 1;
        step();
        check("stall pre ALUResultM", ALUResultM, 32'h33);
        for (int i = 0; i < 3; i++) begin
            StallM = 1; RD1E = 32'(i + 100); RdE = 5'(i + 7); RegWriteE = 0;
            step();
            check("stall hold ALUResultM", ALUResultM,         32'h33);
            check("stall hold RdM",        {27'h0, RdM},       32'd5);
            check("stall hold RegWriteM",  {31'h0, RegWriteM}, 32'd1);
        end
        clear_inputs();
        RD1E = 1; RD2E = 1; RdE = 5'd9;
        step();
        check("stall release ALUResultM", ALUResultM,   32'd2);
        check("stall release RdM",        {27'h0, RdM}, 32'd9);

        // ---------------- flush over stall ----------------
        clear_inputs();
        RD1E = 32'h70; RD2E = 32'h7; RdE = 5'd12; RegWriteE = 1; MemWriteE = 1;
        ResultSrcE = 2'b01; PCPlus4E = 32'h40;
        step();
        check("flush pre RdM", {27'h0, RdM}, 32'd12);
        FlushM = 1; StallM = 1;
        step();
        check_m_zero("flush+stall");

        // ---------------- asynchronous reset mid-operation ----------------
        clear_inputs();
        RD1E = 32'h10; RD2E = 32'h77; RdE = 5'd9; RegWriteE = 1; MemWriteE = 1;
        ResultSrcE = 2'b10; PCPlus4E = 32'h44;
        step();
        check("mid pre PCPlus4M", PCPlus4M, 32'h44);
        #2 rst = 1'b0;
        #1 check_m_zero("mid rst");
        clear_inputs();
        #1 check("rst idle PCSrcE", {30'h0, PCSrcE}, 32'd0);
        rst = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
